// File: rtl/dmem_responder_pkg.sv
// Shared data-memory types for the pipeline's memory path.
// Contents:
//   mem_size_e    - access size encoding (byte/half/word; 3 is reserved)
//   dmem_req_s    - one load/store request
//   dmem_resp_s   - one response (load data + error flag)
//   dmem_state_e  - responder FSM states
//   size_misaligned() - reserved-size / alignment check shared by load and store paths
package riscv_structures;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        is_unsigned;
  } dmem_req_s;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } dmem_resp_s;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  // Size code 3 is reserved and always faults; halves need an even address,
  // words need a word-aligned address.
  function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      MEM_B:   bad = 1'b0;
      MEM_H:   bad = addr_lo[0];
      MEM_W:   bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_responder_load_align.sv
// dmem_load_align: combinational lane extraction and sign/zero extension for
// loads, plus the misalign/reserved-size flag also used to gate stores.
// Ports:
//   word        in  32  full storage word at the addressed index
//   addr_lo     in   2  byte offset within the word
//   size        in   2  0 byte, 1 half, 2 word, 3 reserved
//   is_unsigned in   1  zero-extend byte/half when set
//   data        out 32  extracted, extended value (0 when misaligned)
//   misalign    out  1  reserved size or misaligned address
module dmem_load_align
  import riscv_structures::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = 8'(word >> {addr_lo, 3'b000});
  assign half_sel = 16'(word >> {addr_lo[1], 4'b0000});

  always_comb begin
    misalign = size_misaligned(size, addr_lo);
    data     = '0;
    if (!misalign) begin
      case (size)
        MEM_B:   data = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
        MEM_H:   data = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
        default: data = word;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: target end of the data-memory path. Accepts one load/store
// at a time, applies RISC-V sizing/alignment rules and returns the response a
// fixed LATENCY edges after acceptance (counting the accepting edge).
// Ports:
//   clk, rst_n (synchronous, active-low)
//   req_valid/req_ready, req_we, req_addr, req_wdata, req_size, req_unsigned
//   resp_valid/resp_ready, resp_rdata, resp_err
// Parameters: DEPTH_WORDS (power of two), LATENCY (1..15).
// Optional: define DMEM_TRACE_EN to print one line per acceptance and per
// response handshake.
module dmem_responder
  import riscv_structures::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_req_s   req;
  dmem_resp_s  resp_reg, resp_next;
  dmem_state_e state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;

  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [31:0]   load_data;
  logic [31:0]   wr_data;
  logic [3:0]    be;
  logic          misalign;
  logic          accept;
  logic          unused_addr_bits;

  assign req = '{we: req_we, addr: req_addr, wdata: req_wdata,
                 size: req_size, is_unsigned: req_unsigned};

  // Upper address bits are deliberately ignored: addresses alias modulo the array.
  assign word_idx         = req.addr[AW+1:2];
  assign unused_addr_bits = ^req.addr[31:AW+2];

  // The reset edge is never an accepting edge, so no store slips in during reset.
  assign accept = req_valid && req_ready && rst_n;

  dmem_load_align u_align (
    .word        (rd_word),
    .addr_lo     (req.addr[1:0]),
    .size        (req.size),
    .is_unsigned (req.is_unsigned),
    .data        (load_data),
    .misalign    (misalign)
  );

  // Store data is replicated across lanes so each lane picks its byte at a fixed offset.
  always_comb begin
    be      = '0;
    wr_data = req.wdata;
    case (req.size)
      MEM_B: begin
        be[req.addr[1:0]] = 1'b1;
        wr_data           = {4{req.wdata[7:0]}};
      end
      MEM_H: begin
        be      = req.addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req.wdata[15:0]}};
      end
      MEM_W:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (!(accept && req.we) || misalign) begin
      be = '0;
    end
  end

  // One byte-wide array per lane gives per-byte write enables. The read is
  // combinational because the loaded value is captured into the response
  // register on the accepting edge itself.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (be[gi]) begin
          lane_mem[word_idx] <= wr_data[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = lane_mem[word_idx];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    resp_next  = resp_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          resp_next.rdata = (req.we || misalign) ? 32'd0 : load_data;
          resp_next.err   = misalign;
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      resp_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      resp_reg  <= resp_next;
    end
  end

  assign resp_rdata = resp_reg.rdata;
  assign resp_err   = resp_reg.err;

`ifdef DMEM_TRACE_EN
  always_ff @(posedge clk) begin
    if (accept) begin
      $display("%0t dmem %s addr=%h size=%0d data=%h err=%b", $time,
               req.we ? "ST" : "LD", req.addr, req.size,
               req.we ? req.wdata : load_data, misalign);
    end
    if (rst_n && resp_valid && resp_ready) begin
      $display("%0t dmem resp rdata=%h err=%b", $time, resp_rdata, resp_err);
    end
  end
`else
  // Trace disabled: no display statements.
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed cases followed by randomized
// traffic, checked against a word-array reference model of the memory.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        resp_ready = 1'b1;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          rise;
  } exp_t;

  exp_t        sb[$];
  exp_t        got;
  logic [31:0] mdl [DEPTH];
  int          total = 0;
  int          passed = 0;
  bit          bp_mode = 1'b0;
  bit          rand_rr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: memory as an array of 32-bit words, index = address/4
  // modulo depth; returns the response this request must produce.
  function automatic exp_t model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [1:0] sz, input logic uns, input int acc);
    exp_t        e;
    int          idx;
    int          lo;
    logic [31:0] w;
    bit          err;
    idx = int'((a / 4) % DEPTH);
    lo  = int'(a % 4);
    err = (sz == 2'd3) || (sz == 2'd1 && (lo % 2) == 1) || (sz == 2'd2 && lo != 0);
    e.err   = err;
    e.rdata = 32'd0;
    e.rise  = acc + LAT;
    if (!err) begin
      w = mdl[idx];
      if (we) begin
        case (sz)
          2'd0:    w[8*lo +: 8]  = wd[7:0];
          2'd1:    w[8*lo +: 16] = wd[15:0];
          default: w = wd;
        endcase
        mdl[idx] = w;
      end else begin
        case (sz)
          2'd0: begin
            e.rdata = (w >> (8 * lo)) & 32'hFF;
            if (!uns && e.rdata[7]) e.rdata = e.rdata | 32'hFFFF_FF00;
          end
          2'd1: begin
            e.rdata = (w >> (8 * lo)) & 32'hFFFF;
            if (!uns && e.rdata[15]) e.rdata = e.rdata | 32'hFFFF_0000;
          end
          default: e.rdata = w;
        endcase
      end
    end
    return e;
  endfunction

  // resp_ready driver: later than the other stimulus so mode changes apply the same cycle.
  always @(posedge clk) begin
    #2;
    resp_ready = bp_mode ? 1'b0 : (rand_rr ? ($urandom % 3 != 0) : 1'b1);
  end

  // Issue one request (called at posedge+1); returns at posedge+1 after acceptance.
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic uns);
    int acc;
    bit ok;
    ok = 1'b0;
    acc = 0;
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_wdata = wd;
    req_size = sz;
    req_unsigned = uns;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("req_ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      return;
    end
    sb.push_back(model(we, a, wd, sz, uns, acc));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
    req_size = 2'($urandom);
    req_unsigned = 1'($urandom);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on each new response, checks hold-stability under backpressure
  // and that a handshake clears resp_valid.
  logic        prev_v = 1'b0;
  logic        hs_pend = 1'b0;
  logic [31:0] hold_d = '0;
  logic        hold_e = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v  = 1'b0;
      hs_pend = 1'b0;
    end else begin
      if (hs_pend) check("valid_clear_after_hs", 32'(resp_valid), 32'd0);
      hs_pend = 1'b0;
      if (resp_valid) begin
        check("req_ready_low_in_resp", 32'(req_ready), 32'd0);
        if (!prev_v) begin
          if (sb.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
          end else begin
            got = sb.pop_front();
            check("rdata", resp_rdata, got.rdata);
            check("err", 32'(resp_err), 32'(got.err));
            check("latency_cycle", 32'(cyc), 32'(got.rise));
          end
          hold_d = resp_rdata;
          hold_e = resp_err;
        end else begin
          check("rdata_stable", resp_rdata, hold_d);
          check("err_stable", 32'(resp_err), 32'(hold_e));
        end
        if (resp_ready) hs_pend = 1'b1;
      end
      prev_v = resp_valid;
    end
  end

  initial begin
    logic [31:0] a;
    bit          seen;

    // Reset held for two edges
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed sizing, extension and error cases
    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    do_req(1'b1, 32'h13, 32'h0000_0080, 2'd0, 1'b0);
    do_req(1'b0, 32'h13, 32'h0, 2'd0, 1'b0);
    do_req(1'b0, 32'h13, 32'h0, 2'd0, 1'b1);
    do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    do_req(1'b0, 32'h11, 32'h0, 2'd1, 1'b0);
    do_req(1'b1, 32'h12, 32'hFFFF_FFFF, 2'd2, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 2'd3, 1'b0);
    do_req(1'b1, 32'h16, 32'hABCD_1234, 2'd1, 1'b0);
    do_req(1'b0, 32'h16, 32'h0, 2'd1, 1'b1);
    do_req(1'b0, 32'h14, 32'h0, 2'd1, 1'b0);
    drain();

    // Backpressure: hold resp_ready low for five cycles of valid response
    bp_mode = 1'b1;
    do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_resp_seen", 32'(seen), 32'd1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    bp_mode = 1'b0;
    drain();

    // Reset while the store's response is still pending
    do_req(1'b1, 32'h20, 32'h1234_5678, 2'd2, 1'b0);
    rst_n = 1'b0;
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("midrst_no_resp", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1;
    do_req(1'b0, 32'h20, 32'h0, 2'd2, 1'b0);
    do_req(1'b0, 32'h20 + 4 * DEPTH, 32'h0, 2'd2, 1'b0);
    drain();

    // Randomized traffic over 16 words, reached through aliased addresses
    for (int i = 0; i < 16; i++) do_req(1'b1, 32'(i * 4), $urandom, 2'd2, 1'b0);
    rand_rr = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = (32'($urandom_range(0, 7)) << (AW + 2)) | (32'($urandom_range(0, 15)) << 2)
        | 32'($urandom_range(0, 3));
      do_req(1'($urandom), a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom));
    end
    @(posedge clk);
    #1;
    rand_rr = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
